pid_pwm_driver: RTL and testbench

- Downstream stage of the PID controller. Consumes the 8-bit control word and produces a complementary, dead-time-protected PWM pair for a half-bridge.
- Duty updates are double-buffered: a new value is captured into a shadow register and applied only at a period boundary, so no glitched or truncated pulses occur.
- Sits between the PID control output and the chip output pins.

---
 rtl/pid_pkg.sv | 13 +
 rtl/pid_pwm_driver_if.sv | 23 ++
 rtl/pwm_deadtime.sv | 73 +++++++
 rtl/pid_pwm_driver.sv | 105 ++++++++++
 tb/tb_pid_pwm_driver.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pid_pkg.sv
// Shared types and constants for the PID output stage: dead-time FSM states and
// the PWM period / duty widths.
package pid_pkg;
  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] PWM_MAX = 8'd254;

  typedef enum logic [1:0] {
    IDLE,
    HI_ON,
    LO_ON,
    DT
  } dt_state_t;
endpackage

// File: rtl/pid_pwm_driver_if.sv
// Control-word bus between the PID stage (master) and the PWM driver (slave).
interface pid_pwm_driver_if;
  import pid_pkg::*;

  logic              enable;
  logic [DUTY_W-1:0] duty_in;
  logic              duty_valid;
  logic              pwm_hi;
  logic              pwm_lo;
  logic              period_start;
  logic [DUTY_W-1:0] duty_active;
  logic              pending;

  modport master (
    output enable, duty_in, duty_valid,
    input  pwm_hi, pwm_lo, period_start, duty_active, pending
  );

  modport slave (
    input  enable, duty_in, duty_valid,
    output pwm_hi, pwm_lo, period_start, duty_active, pending
  );
endinterface

// File: rtl/pwm_deadtime.sv
// Dead-time FSM: turns the raw PWM level into a break-before-make high/low pair.
// Outputs come straight from flops so the pins never see decode glitches.
module pwm_deadtime
  import pid_pkg::*;
#(
  parameter int DEADTIME = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic raw,
  output logic pwm_hi,
  output logic pwm_lo
);

  localparam int DtLoad = (DEADTIME > 0) ? DEADTIME - 1 : 0;

  dt_state_t  state_q, state_d;
  logic [3:0] dt_cnt_q, dt_cnt_d;
  logic       hi_q, lo_q;
  logic       leave;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred; blocking '=' is correct here.
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    leave    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    leave = 1'b1;
        HI_ON:   leave = !raw;
        LO_ON:   leave = raw;
        DT: begin
          // raw is sampled at expiry, not on entry, so short pulses collapse
          if (dt_cnt_q == 4'd0) state_d = raw ? HI_ON : LO_ON;
          else                  dt_cnt_d = dt_cnt_q - 4'd1;
        end
        default: state_d = IDLE;
      endcase
      if (leave) begin
        if (DEADTIME == 0) begin
          state_d = raw ? HI_ON : LO_ON;
        end else begin
          state_d  = DT;
          dt_cnt_d = 4'(DtLoad);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update together
  // from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dt_cnt_q <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dt_cnt_q <= dt_cnt_d;
      hi_q     <= (state_d == HI_ON);
      lo_q     <= (state_d == LO_ON);
    end
  end

  assign pwm_hi = hi_q;
  assign pwm_lo = lo_q;

endmodule

// File: rtl/pid_pwm_driver.sv
// PWM driver top: prescaler, 255-tick period counter, double-buffered duty and
// the duty compare feeding the dead-time stage.
module pid_pwm_driver
  import pid_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int DEADTIME = 4
) (
  input logic               clk,
  input logic               rst,
  pid_pwm_driver_if.slave   bus
);

  logic [7:0]        presc_q, presc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic              pending_q, pending_d;
  logic              ps_q, ps_d;
  logic              raw_q, raw_d;
  logic              en_q;
  logic              tick, wrap;

  assign tick = (presc_q == 8'(PRESCALE - 1));
  assign wrap = tick && (cnt_q == PWM_MAX);

  always_comb begin
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    ps_d      = 1'b0;
    raw_d     = 1'b0;

    // shadow capture runs regardless of enable; last write in a period wins
    if (bus.duty_valid) begin
      shadow_d  = bus.duty_in;
      pending_d = 1'b1;
    end

    if (!bus.enable) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (!en_q) begin
      presc_d   = '0;
      cnt_d     = '0;
      active_d  = bus.duty_valid ? bus.duty_in : shadow_q;
      pending_d = 1'b0;
      ps_d      = 1'b1;
    end else begin
      raw_d = (cnt_q < active_q);
      if (tick) begin
        presc_d = '0;
        cnt_d   = wrap ? '0 : cnt_q + 8'd1;
      end else begin
        presc_d = presc_q + 8'd1;
      end
      // a write landing on the wrap edge bypasses the shadow
      if (wrap) begin
        active_d  = bus.duty_valid ? bus.duty_in : shadow_q;
        pending_d = 1'b0;
        ps_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      ps_q      <= 1'b0;
      raw_q     <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ps_q      <= ps_d;
      raw_q     <= raw_d;
      en_q      <= bus.enable;
    end
  end

  pwm_deadtime #(
    .DEADTIME (DEADTIME)
  ) u_deadtime (
    .clk    (clk),
    .rst    (rst),
    .enable (bus.enable),
    .raw    (raw_q),
    .pwm_hi (bus.pwm_hi),
    .pwm_lo (bus.pwm_lo)
  );

  assign bus.period_start = ps_q;
  assign bus.duty_active  = active_q;
  assign bus.pending      = pending_q;

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Directed bench for pid_pwm_driver: a duty table measured over steady periods,
// plus hand sequences for shadow timing, enable gaps, reset and a prescaled build.
module tb_pid_pwm_driver;
  import pid_pkg::*;

  typedef struct {
    logic [7:0] duty;
    int         exp_hi;
    int         exp_lo;
    int         exp_dead;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic sel6;
  logic m_hi, m_lo, m_ps;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   overlap = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  pid_pwm_driver_if bus  ();
  pid_pwm_driver_if bus6 ();

  pid_pwm_driver #(.PRESCALE(1), .DEADTIME(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pid_pwm_driver #(.PRESCALE(3), .DEADTIME(0)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  assign m_hi = sel6 ? bus6.pwm_hi       : bus.pwm_hi;
  assign m_lo = sel6 ? bus6.pwm_lo       : bus.pwm_lo;
  assign m_ps = sel6 ? bus6.period_start : bus.period_start;

  always @(negedge clk) begin
    if (bus.pwm_hi && bus.pwm_lo)   overlap++;
    if (bus6.pwm_hi && bus6.pwm_lo) overlap++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic pulse_duty(input logic [7:0] d);
    bus.duty_in    = d;
    bus.duty_valid = 1'b1;
    step();
    bus.duty_valid = 1'b0;
  endtask

  task automatic wait_ps(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!m_ps && n < budget);
    if (!m_ps) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_ps: period_start not seen within %0d cycles", budget);
    end
  endtask

  task automatic measure(input int n, output int hi_n, output int lo_n,
                         output int dead_n, output int comp_err, output int ps_pos);
    hi_n = 0; lo_n = 0; dead_n = 0; comp_err = 0; ps_pos = -1;
    for (int i = 1; i <= n; i++) begin
      step();
      if (m_hi) hi_n++;
      if (m_lo) lo_n++;
      if (!m_hi && !m_lo) dead_n++;
      if (m_lo == m_hi) comp_err++;
      if (m_ps) ps_pos = (ps_pos < 0) ? i : 10000;
    end
  endtask

  task automatic check_startup(input string tag, input logic exp_hi);
    int dead_n = 0;
    for (int i = 0; i < 4; i++) begin
      if (!bus.pwm_hi && !bus.pwm_lo) dead_n++;
      step();
    end
    check({tag, "_deadtime"}, dead_n, 4);
    check({tag, "_hi"}, bus.pwm_hi, int'(exp_hi));
    check({tag, "_lo"}, bus.pwm_lo, int'(!exp_hi));
  endtask

  initial begin
    int n, hi_n, lo_n, dead_n, comp_err, ps_pos, bad;

    vecs[0] = '{8'd128, 124, 123, 8};
    vecs[1] = '{8'd0,     0, 255, 0};
    vecs[2] = '{8'd255, 255,   0, 0};
    vecs[3] = '{8'd3,     0, 251, 4};
    vecs[4] = '{8'd5,     1, 246, 8};
    vecs[5] = '{8'd250, 246,   1, 8};
    vecs[6] = '{8'd252, 251,   0, 4};
    vecs[7] = '{8'd64,   60, 187, 8};

    rst = 1'b1; sel6 = 1'b0;
    bus.enable  = 1'b0; bus.duty_in  = '0; bus.duty_valid  = 1'b0;
    bus6.enable = 1'b0; bus6.duty_in = '0; bus6.duty_valid = 1'b0;
    repeat (3) step();
    check("rst_hi", bus.pwm_hi, 0);
    check("rst_lo", bus.pwm_lo, 0);
    check("rst_ps", bus.period_start, 0);
    check("rst_active", bus.duty_active, 0);
    check("rst_pending", bus.pending, 0);

    // shadow capture while disabled, last write wins, then duty-0 startup
    rst = 1'b0;
    pulse_duty(8'd200);
    pulse_duty(8'd0);
    check("dis_pending", bus.pending, 1);
    check("dis_active", bus.duty_active, 0);
    bus.enable = 1'b1;
    step();
    check("start_ps", bus.period_start, 1);
    check("start_active", bus.duty_active, 0);
    check("start_pending", bus.pending, 0);
    check_startup("start", 1'b0);

    for (int v = 0; v < 8; v++) begin
      pulse_duty(vecs[v].duty);
      wait_ps(600, n);
      check("vec_load", bus.duty_active, int'(vecs[v].duty));
      wait_ps(300, n);
      measure(255, hi_n, lo_n, dead_n, comp_err, ps_pos);
      check("vec_hi", hi_n, vecs[v].exp_hi);
      check("vec_lo", lo_n, vecs[v].exp_lo);
      check("vec_dead", dead_n, vecs[v].exp_dead);
      check("vec_period", ps_pos, 255);
    end

    // shadow update mid-period, then a write exactly on the wrap edge
    repeat (50) step();
    pulse_duty(8'd200);
    check("mid_pending", bus.pending, 1);
    check("mid_active", bus.duty_active, 64);
    repeat (203) step();
    check("pre_wrap_pending", bus.pending, 1);
    check("pre_wrap_active", bus.duty_active, 64);
    check("pre_wrap_ps", bus.period_start, 0);
    step();
    check("wrap_ps", bus.period_start, 1);
    check("wrap_active", bus.duty_active, 200);
    check("wrap_pending", bus.pending, 0);
    repeat (254) step();
    pulse_duty(8'd77);
    check("bypass_ps", bus.period_start, 1);
    check("bypass_active", bus.duty_active, 77);
    check("bypass_pending", bus.pending, 0);

    // enable gap at cnt=100 for 10 clk
    pulse_duty(8'd128);
    wait_ps(300, n);
    repeat (100) step();
    check("pre_dis_hi", bus.pwm_hi, 1);
    bus.enable = 1'b0;
    step();
    check("dis_hi", bus.pwm_hi, 0);
    check("dis_lo", bus.pwm_lo, 0);
    bad = 0;
    repeat (9) begin
      step();
      if (bus.pwm_hi || bus.pwm_lo || bus.period_start) bad++;
    end
    check("dis_quiet", bad, 0);
    bus.enable = 1'b1;
    step();
    check("reen_ps", bus.period_start, 1);
    check("reen_active", bus.duty_active, 128);
    check_startup("reen", 1'b1);
    wait_ps(300, n);
    check("reen_period", n, 251);

    // reset mid-period with a pending write
    repeat (60) step();
    pulse_duty(8'd99);
    step();
    check("pre_rst_pending", bus.pending, 1);
    rst = 1'b1;
    step();
    check("mrst_hi", bus.pwm_hi, 0);
    check("mrst_lo", bus.pwm_lo, 0);
    check("mrst_ps", bus.period_start, 0);
    check("mrst_active", bus.duty_active, 0);
    check("mrst_pending", bus.pending, 0);
    rst = 1'b0;
    step();
    check("post_rst_ps", bus.period_start, 1);
    check("post_rst_active", bus.duty_active, 0);
    check_startup("post_rst", 1'b0);

    // prescaled build with no dead time
    bus6.duty_in    = 8'd10;
    bus6.duty_valid = 1'b1;
    step();
    bus6.duty_valid = 1'b0;
    bus6.enable     = 1'b1;
    sel6            = 1'b1;
    wait_ps(800, n);
    wait_ps(800, n);
    check("p3_period", n, 765);
    measure(765, hi_n, lo_n, dead_n, comp_err, ps_pos);
    check("p3_hi", hi_n, 30);
    check("p3_lo", lo_n, 735);
    check("p3_complement", comp_err, 0);
    check("p3_ps_pos", ps_pos, 765);

    check("never_both_high", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
